syncgen_prog: RTL

SYNCGEN_PROG -- requirements
Module: syncgen_prog

---
 rtl/syncgen_prog.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/syncgen_prog.sv
// Programmable monitor sync and Z80 interrupt generator. Re-times the CRTC
// HSYNC/VSYNC into monitor syncs, derives a line tick, and raises INT_N
// either periodically (every INT_PERIOD lines, realigned on vsync) or on a
// programmed raster line.
module syncgen_prog #(
  parameter int unsigned INT_PERIOD = 52,
  parameter int unsigned INT_THR    = 32,
  parameter int unsigned HS_DELAY   = 2,
  parameter int unsigned HS_WIDTH   = 4,
  parameter int unsigned VS_DELAY   = 2,
  parameter int unsigned VS_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          CCLK_EN,
  input  logic                          HSYNC_I,
  input  logic                          VSYNC_I,
  input  logic                          M1_N,
  input  logic                          IORQ_N,
  input  logic                          irq_reset,
  input  logic                          pri_en,
  input  logic [7:0]                    pri_line,
  output logic                          HSYNC_O,
  output logic                          VSYNC_O,
  output logic                          SYNC_N,
  output logic                          INT_N,
  output logic                          mode_sync_en,
  output logic [$clog2(INT_PERIOD)-1:0] intcnt_o,
  output logic                          pri_flag
);

  localparam int unsigned CW = $clog2(INT_PERIOD);
  localparam int unsigned HW = $clog2(HS_DELAY + HS_WIDTH + 1);
  localparam int unsigned VW = $clog2(VS_DELAY + VS_WIDTH + 1);

  localparam logic [HW-1:0] HS_ON    = HW'(HS_DELAY);
  localparam logic [HW-1:0] HS_MAX   = HW'(HS_DELAY + HS_WIDTH);
  localparam logic [VW-1:0] VS_ON    = VW'(VS_DELAY);
  localparam logic [VW-1:0] VS_MAX   = VW'(VS_DELAY + VS_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(INT_PERIOD - 1);
  localparam logic [CW-1:0] THR_VAL  = CW'(INT_THR);
  localparam logic [CW-1:0] THR_MASK = CW'(INT_THR - 1);

  // Registered state
  logic          hs_in_q;
  logic          vs_in_q;
  logic          lt;
  logic          vs_rise_q;
  logic          vs_active;
  logic          ack_q;
  logic [HW-1:0] hs_cnt;
  logic [VW-1:0] vs_cnt;
  logic [7:0]    raster_cnt;

  // Next-state values
  logic [HW-1:0] hs_cnt_nxt;
  logic [VW-1:0] vs_cnt_nxt;
  logic [7:0]    raster_nxt;
  logic [CW-1:0] intcnt_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          vs_o_rise;
  logic          ack_cond;
  logic          ack;
  logic          per_set;
  logic          ras_set;
  logic          int_n_nxt;
  logic          pri_flag_nxt;

  // Sync counters and their decoded outputs
  always_comb begin
    hs_cnt_nxt = hs_cnt;
    if (!HSYNC_I) begin
      hs_cnt_nxt = '0;
    end else if (CCLK_EN && (hs_cnt != HS_MAX)) begin
      hs_cnt_nxt = hs_cnt + HW'(1);
    end
    hsync_nxt = HSYNC_I && (hs_cnt_nxt >= HS_ON) && (hs_cnt_nxt < HS_MAX);

    // vsync counter stays idle until the first VSYNC_I rise after reset
    vs_cnt_nxt = vs_cnt;
    if (vs_rise_q) begin
      vs_cnt_nxt = '0;
    end else if (lt && vs_active && (vs_cnt != VS_MAX)) begin
      vs_cnt_nxt = vs_cnt + VW'(1);
    end
    vsync_nxt = (vs_cnt_nxt >= VS_ON) && (vs_cnt_nxt < VS_MAX);
    vs_o_rise = vsync_nxt && !VSYNC_O;
  end

  // Interrupt sources, acknowledge and counter next-state
  always_comb begin
    ack_cond = !INT_N && !IORQ_N && !M1_N;
    ack      = ack_cond && !ack_q;

    // vsync realignment takes precedence over the line-tick wrap
    per_set = 1'b0;
    if (!pri_en) begin
      if (vs_o_rise) begin
        per_set = (intcnt_o >= THR_VAL);
      end else begin
        per_set = lt && (intcnt_o == CNT_LAST);
      end
    end
    ras_set = pri_en && lt && (raster_cnt == pri_line);

    intcnt_nxt = intcnt_o;
    if (vs_o_rise) begin
      intcnt_nxt = '0;
    end else if (lt) begin
      intcnt_nxt = (intcnt_o == CNT_LAST) ? '0 : intcnt_o + CW'(1);
    end else if (ack && !pri_flag) begin
      intcnt_nxt = intcnt_o & THR_MASK;
    end

    raster_nxt = raster_cnt;
    if (vs_o_rise) begin
      raster_nxt = '0;
    end else if (lt) begin
      raster_nxt = raster_cnt + 8'd1;
    end

    int_n_nxt    = INT_N;
    pri_flag_nxt = pri_flag;
    if (per_set || ras_set) begin
      int_n_nxt    = 1'b0;
      pri_flag_nxt = ras_set;
    end else if (ack) begin
      int_n_nxt    = 1'b1;
      pri_flag_nxt = 1'b0;
    end

    if (irq_reset) begin
      int_n_nxt    = 1'b1;
      pri_flag_nxt = 1'b0;
      intcnt_nxt   = '0;
    end
  end

  // State and output registers; edge detectors reload their input in reset
  always_ff @(posedge clk) begin
    if (RESET) begin
      hs_in_q      <= HSYNC_I;
      vs_in_q      <= VSYNC_I;
      lt           <= 1'b0;
      vs_rise_q    <= 1'b0;
      vs_active    <= 1'b0;
      ack_q        <= 1'b0;
      hs_cnt       <= '0;
      vs_cnt       <= '0;
      raster_cnt   <= '0;
      intcnt_o     <= '0;
      HSYNC_O      <= 1'b0;
      VSYNC_O      <= 1'b0;
      SYNC_N       <= 1'b1;
      INT_N        <= 1'b1;
      pri_flag     <= 1'b0;
      mode_sync_en <= 1'b0;
    end else begin
      hs_in_q      <= HSYNC_I;
      vs_in_q      <= VSYNC_I;
      lt           <= hs_in_q && !HSYNC_I;
      vs_rise_q    <= VSYNC_I && !vs_in_q;
      if (vs_rise_q) begin
        vs_active  <= 1'b1;
      end
      ack_q        <= ack_cond;
      hs_cnt       <= hs_cnt_nxt;
      vs_cnt       <= vs_cnt_nxt;
      raster_cnt   <= raster_nxt;
      intcnt_o     <= intcnt_nxt;
      HSYNC_O      <= hsync_nxt;
      VSYNC_O      <= vsync_nxt;
      SYNC_N       <= !(hsync_nxt ^ vsync_nxt);
      INT_N        <= int_n_nxt;
      pri_flag     <= pri_flag_nxt;
      mode_sync_en <= HSYNC_O && !hsync_nxt;
    end
  end

endmodule
